// File: rtl/instr_mem_pipelined.sv
// Writable instruction memory with a LATENCY-deep registered read pipeline.
// Fetches use a valid/ready handshake on both sides, and every response
// carries a fault code. Programs are written through the load port.
module instr_mem_pipelined #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    DEPTH      = 64,
  parameter int                    LATENCY    = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
  input  logic                       CLK,
  input  logic                       Reset,
  input  logic                       ReqValid,
  output logic                       ReqReady,
  input  logic [ADDR_WIDTH-1:0]      Address,
  output logic                       RspValid,
  input  logic                       RspReady,
  output logic [DATA_WIDTH-1:0]      Data,
  output logic [1:0]                 FaultCode,
  input  logic                       LoadEn,
  input  logic [$clog2(DEPTH)-1:0]   LoadAddr,
  input  logic [DATA_WIDTH-1:0]      LoadData
);

  localparam int IDX_W = $clog2(DEPTH);

  localparam logic [1:0] FLT_OK       = 2'b00;
  localparam logic [1:0] FLT_MISALIGN = 2'b01;
  localparam logic [1:0] FLT_RANGE    = 2'b10;

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instr_mem_pipelined: LATENCY must be in 1..4");
  end
  if (DEPTH < 2 || (1 << IDX_W) != DEPTH) begin : g_bad_depth
    $error("instr_mem_pipelined: DEPTH must be a power of two >= 2");
  end

  // Misalignment wins over out-of-range when both apply.
  function automatic logic [1:0] decode_fault(input logic [ADDR_WIDTH-1:0] a);
    logic [1:0] f;
    f = FLT_OK;
    if (a[1:0] != 2'b00) begin
      f = FLT_MISALIGN;
    end else if (|a[ADDR_WIDTH-1:IDX_W+2]) begin
      f = FLT_RANGE;
    end
    return f;
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Pipeline stage registers: index 0 is stage 1, index LATENCY-1 drives outputs.
  logic                  vld_p   [LATENCY];
  logic [DATA_WIDTH-1:0] data_p  [LATENCY];
  logic [1:0]            fault_p [LATENCY];

  logic                  stall;
  logic                  accept;
  logic [IDX_W-1:0]      req_idx;
  logic [1:0]            s1_fault;
  logic [DATA_WIDTH-1:0] s1_data;

  assign stall    = vld_p[LATENCY-1] & ~RspReady;
  assign ReqReady = ~stall & ~LoadEn & ~Reset;
  assign accept   = ReqValid & ReqReady;

  assign req_idx  = Address[IDX_W+1:2];
  assign s1_fault = decode_fault(Address);
  assign s1_data  = (s1_fault == FLT_OK) ? mem[req_idx] : FILL_WORD;

  // Load port: a load never collides with a fetch because ReqReady is low.
  always_ff @(posedge CLK) begin
    if (LoadEn && !Reset) begin
      mem[LoadAddr] <= LoadData;
    end
  end

  // Read pipeline: stage 1 captures on accept; every stage freezes while stalled.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        vld_p[i]   <= 1'b0;
        data_p[i]  <= '0;
        fault_p[i] <= FLT_OK;
      end
    end else if (!stall) begin
      // stage 1 boundary
      vld_p[0] <= accept;
      if (accept) begin
        data_p[0]  <= s1_data;
        fault_p[0] <= s1_fault;
      end
      // stages 2..LATENCY boundary
      for (int i = 1; i < LATENCY; i++) begin
        vld_p[i]   <= vld_p[i-1];
        data_p[i]  <= data_p[i-1];
        fault_p[i] <= fault_p[i-1];
      end
    end
  end

  assign RspValid  = vld_p[LATENCY-1];
  assign Data      = data_p[LATENCY-1];
  assign FaultCode = fault_p[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Directed bench for instr_mem_pipelined: a LATENCY=2 main instance plus
// LATENCY=1 and LATENCY=4 instances driven by the same stimulus.
module tb_instr_mem_pipelined;

  localparam logic [31:0] FILL = 32'hDEADBEEF;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [63:0] address;
  logic        rsp_ready;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;

  logic        req_ready_m, rsp_valid_m;
  logic [31:0] data_m;
  logic [1:0]  fault_m;
  logic        req_ready_1, rsp_valid_1;
  logic [31:0] data_1;
  logic [1:0]  fault_1;
  logic        req_ready_4, rsp_valid_4;
  logic [31:0] data_4;
  logic [1:0]  fault_4;

  int checks = 0;
  int errors = 0;

  logic [33:0] qm[$];
  logic [33:0] q4[$];

  logic [31:0] words [8] = '{32'hF84003E9, 32'hF84083EA, 32'hF84103EB, 32'hF84183EC,
                             32'h00500093, 32'h00A00113, 32'h002081B3, 32'h40110233};

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic [1:0]  fault;
  } vec_t;
  vec_t vecs [10];

  instr_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(64), .LATENCY(2), .FILL_WORD(FILL)) dut_m (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(req_ready_m), .Address(address),
    .RspValid(rsp_valid_m), .RspReady(rsp_ready), .Data(data_m), .FaultCode(fault_m),
    .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data));

  instr_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(64), .LATENCY(1), .FILL_WORD(FILL)) dut_1 (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(req_ready_1), .Address(address),
    .RspValid(rsp_valid_1), .RspReady(rsp_ready), .Data(data_1), .FaultCode(fault_1),
    .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data));

  instr_mem_pipelined #(.DATA_WIDTH(32), .ADDR_WIDTH(64), .DEPTH(64), .LATENCY(4), .FILL_WORD(FILL)) dut_4 (
    .CLK(clk), .Reset(rst), .ReqValid(req_valid), .ReqReady(req_ready_4), .Address(address),
    .RspValid(rsp_valid_4), .RspReady(rsp_ready), .Data(data_4), .FaultCode(fault_4),
    .LoadEn(load_en), .LoadAddr(load_addr), .LoadData(load_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record each response that retires (sampled mid-cycle, before its retire edge).
  always @(negedge clk) begin
    if (!rst && rsp_valid_m && rsp_ready) qm.push_back({fault_m, data_m});
    if (!rst && rsp_valid_4 && rsp_ready) q4.push_back({fault_4, data_4});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [5:0] idx, input logic [31:0] d);
    load_en = 1'b1; load_addr = idx; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic wait_rsp(input string name, input int n_exp);
    int n;
    n = 0;
    while (qm.size() < n_exp && n < 20) begin
      tick();
      n++;
    end
    if (qm.size() < n_exp) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d responses, expected %0d", name, qm.size(), n_exp);
    end
  endtask

  task automatic fetch1(input string name, input logic [63:0] a, input logic [31:0] ed, input logic [1:0] ef);
    qm.delete();
    req_valid = 1'b1; address = a;
    tick();
    req_valid = 1'b0;
    wait_rsp(name, 1);
    if (qm.size() > 0) begin
      check({name, "_data"}, 64'(qm[0][31:0]), 64'(ed));
      check({name, "_fault"}, 64'(qm[0][33:32]), 64'(ef));
    end
  endtask

  initial begin
    int  i;
    bit  acc;
    logic [63:0] lat_exp;

    rst = 1'b1; req_valid = 1'b0; address = '0; rsp_ready = 1'b1;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    tick(); tick();
    check("reset_rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("reset_data", 64'(data_m), 64'd0);
    check("reset_fault", 64'(fault_m), 64'd0);
    check("reset_req_ready", 64'(req_ready_m), 64'd0);
    rst = 1'b0;
    tick();

    for (int k = 0; k < 8; k++) load_word(6'(k), words[k]);
    load_word(6'd63, 32'h0000006F);

    // Table-driven fetches, back-to-back, no back-pressure.
    vecs[0] = '{64'h0,   32'hF84003E9, 2'b00};
    vecs[1] = '{64'h4,   32'hF84083EA, 2'b00};
    vecs[2] = '{64'h8,   32'hF84103EB, 2'b00};
    vecs[3] = '{64'hC,   32'hF84183EC, 2'b00};
    vecs[4] = '{64'h6,   FILL,         2'b01};
    vecs[5] = '{64'h100, FILL,         2'b10};
    vecs[6] = '{64'h102, FILL,         2'b01};
    vecs[7] = '{64'hFC,  32'h0000006F, 2'b00};
    vecs[8] = '{64'h8000_0000_0000_0000, FILL, 2'b10};
    vecs[9] = '{64'h3,   FILL,         2'b01};
    qm.delete();
    for (int v = 0; v < 10; v++) begin
      req_valid = 1'b1; address = vecs[v].addr;
      #1;
      check("tbl_req_ready", 64'(req_ready_m), 64'd1);
      tick();
    end
    req_valid = 1'b0;
    wait_rsp("tbl", 10);
    check("tbl_count", 64'(qm.size()), 64'd10);
    for (int v = 0; v < 10; v++) begin
      if (v < qm.size()) begin
        check($sformatf("tbl%0d_data", v), 64'(qm[v][31:0]), 64'(vecs[v].data));
        check($sformatf("tbl%0d_fault", v), 64'(qm[v][33:32]), 64'(vecs[v].fault));
      end
    end

    // Back-pressure: stream 0x0..0x1C, consumer stalls in cycles 4..6.
    qm.delete();
    i = 0;
    for (int cyc = 0; cyc < 60 && (i < 8 || qm.size() < 8); cyc++) begin
      req_valid = (i < 8);
      address   = 64'(i * 4);
      rsp_ready = !(cyc >= 4 && cyc <= 6);
      #1;
      if (cyc >= 4 && cyc <= 6) begin
        check("bp_req_ready", 64'(req_ready_m), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid_m), 64'd1);
        if (qm.size() < 8) check("bp_data_hold", 64'(data_m), 64'(words[qm.size()]));
      end
      acc = req_valid && req_ready_m;
      tick();
      if (acc) i++;
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    check("bp_count", 64'(qm.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      if (k < qm.size()) check($sformatf("bp%0d_data", k), 64'(qm[k][31:0]), 64'(words[k]));
    end
    repeat (6) tick();

    // Load blocks fetch; the next accepted fetch sees the new word.
    qm.delete();
    req_valid = 1'b1; address = 64'h14;
    load_en = 1'b1; load_addr = 6'd5; load_data = 32'h8B0901AD;
    #1;
    check("load_req_ready", 64'(req_ready_m), 64'd0);
    tick();
    load_en = 1'b0;
    #1;
    check("post_load_req_ready", 64'(req_ready_m), 64'd1);
    tick();
    req_valid = 1'b0;
    wait_rsp("load_vis", 1);
    repeat (4) tick();
    check("load_vis_count", 64'(qm.size()), 64'd1);
    if (qm.size() > 0) check("load_vis_data", 64'(qm[0][31:0]), 64'h8B0901AD);

    // Reset mid-flight with a load attempted during reset.
    qm.delete(); q4.delete();
    for (int j = 0; j < 3; j++) begin
      req_valid = 1'b1; address = 64'(j * 4);
      tick();
    end
    req_valid = 1'b0;
    rst = 1'b1; load_en = 1'b1; load_addr = 6'd1; load_data = 32'h0BADF00D;
    #1;
    check("rst_req_ready", 64'(req_ready_m), 64'd0);
    tick();
    rst = 1'b0; load_en = 1'b0;
    #1;
    check("rst_mid_rsp_valid", 64'(rsp_valid_m), 64'd0);
    check("rst_mid_data", 64'(data_m), 64'd0);
    check("rst_mid_fault", 64'(fault_m), 64'd0);
    check("rst_mid_rsp_valid_l4", 64'(rsp_valid_4), 64'd0);
    repeat (8) tick();
    check("rst_mid_retired_l2", 64'(qm.size()), 64'd1);
    check("rst_mid_retired_l4", 64'(q4.size()), 64'd0);
    if (qm.size() > 0) check("rst_mid_first_data", 64'(qm[0][31:0]), 64'hF84003E9);
    fetch1("rst_keep_w1", 64'h4, 32'hF84083EA, 2'b00);
    fetch1("rst_keep_w2", 64'h8, 32'hF84103EB, 2'b00);
    fetch1("boundary_w63", 64'hFC, 32'h0000006F, 2'b00);
    repeat (6) tick();

    // Latency sweep: first RspValid after LATENCY cycles for 1, 2 and 4.
    req_valid = 1'b1; address = 64'h0;
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      #1;
      check($sformatf("lat1_c%0d_valid", c), 64'(rsp_valid_1), 64'(c == 1));
      check($sformatf("lat2_c%0d_valid", c), 64'(rsp_valid_m), 64'(c == 2));
      check($sformatf("lat4_c%0d_valid", c), 64'(rsp_valid_4), 64'(c == 4));
      lat_exp = 64'hF84003E9;
      if (c == 1) check("lat1_data", 64'(data_1), lat_exp);
      if (c == 2) check("lat2_data", 64'(data_m), lat_exp);
      if (c == 4) check("lat4_data", 64'(data_4), lat_exp);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
